// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings and counter-width helper for the universal shift register.
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ROL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;

  // Bits needed to hold 0..width; the counter itself only reaches width-1.
  function automatic int calc_cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/univ_shift_reg_shift_cnt.sv
// Wrap counter over WIDTH shift ops; raises done for one cycle after each wrap.
module shift_cnt #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          done
);

  logic [CW-1:0] r_cnt;
  logic          r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (inc) begin
      if (r_cnt == CW'(WIDTH - 1)) begin
        r_cnt  <= '0;
        r_done <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign cnt  = r_cnt;
  assign done = r_done;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, rotate, load, clear, with a wrap counter
// so it can serve directly as a PISO/SIPO stage.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  localparam int              CW      = calc_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pdin,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_shift;
  logic             w_clr;

  always_comb begin
    w_q_nxt = r_q;
    w_shift = 1'b0;
    w_clr   = 1'b0;
    if (en) begin
      unique case (mode)
        MODE_SHL:   begin w_q_nxt = {r_q[WIDTH-2:0], sin};        w_shift = 1'b1; end
        MODE_SHR:   begin w_q_nxt = {sin, r_q[WIDTH-1:1]};        w_shift = 1'b1; end
        MODE_ROL:   begin w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]}; w_shift = 1'b1; end
        MODE_ROR:   begin w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};     w_shift = 1'b1; end
        MODE_LOAD:  begin w_q_nxt = pdin;                         w_clr   = 1'b1; end
        MODE_CLEAR: begin w_q_nxt = RST_VAL;                      w_clr   = 1'b1; end
        default:    w_q_nxt = r_q; // HOLD and reserved 111
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_q <= RST_VAL;
    else      r_q <= w_q_nxt;
  end

  shift_cnt #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_shift),
    .clr  (w_clr),
    .cnt  (cnt),
    .done (done)
  );

  assign q      = r_q;
  assign sout_l = r_q[WIDTH-1];
  assign sout_r = r_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: reference model plus per-cycle compare and
// literal checks for each scenario.
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'd0;
  logic         sin = 1'b0;
  logic [W-1:0] pdin = '0;
  logic [W-1:0] q;
  logic         sout_l, sout_r;
  logic [3:0]   cnt;
  logic         done;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin), .pdin(pdin),
    .q(q), .sout_l(sout_l), .sout_r(sout_r), .cnt(cnt), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: value plus total shifts since last load/clear; cnt is that modulo W.
  logic [W-1:0] m_q;
  int           m_tot;
  logic         m_done;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q <= '0; m_tot <= 0; m_done <= 1'b0;
    end else if (!en) begin
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      case (mode)
        3'd1: begin m_q <= W'((m_q << 1) | W'(sin));            m_tot <= m_tot + 1; m_done <= ((m_tot + 1) % W) == 0; end
        3'd2: begin m_q <= W'((m_q >> 1) | (W'(sin) << (W-1))); m_tot <= m_tot + 1; m_done <= ((m_tot + 1) % W) == 0; end
        3'd3: begin m_q <= W'((m_q << 1) | (m_q >> (W-1)));     m_tot <= m_tot + 1; m_done <= ((m_tot + 1) % W) == 0; end
        3'd4: begin m_q <= W'((m_q >> 1) | (m_q << (W-1)));     m_tot <= m_tot + 1; m_done <= ((m_tot + 1) % W) == 0; end
        3'd5: begin m_q <= pdin; m_tot <= 0; end
        3'd6: begin m_q <= '0;   m_tot <= 0; end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_q",      32'(q),      32'(m_q));
      check("cyc_sout_l", 32'(sout_l), 32'(m_q[W-1]));
      check("cyc_sout_r", 32'(sout_r), 32'(m_q[0]));
      check("cyc_cnt",    32'(cnt),    32'(m_tot % W));
      check("cyc_done",   32'(done),   32'(m_done));
    end
  end

  task automatic step(input logic e, input logic [2:0] m, input logic s, input logic [W-1:0] p);
    en = e; mode = m; sin = s; pdin = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dsum;
    logic [7:0] pat;
    logic [7:0] exp_l;

    // 1. reset
    #50;
    check("rst_q", 32'(q), 32'h00);
    check("rst_cnt", 32'(cnt), 0);
    check("rst_done", 32'(done), 0);
    #51 rst = 1'b1;
    chk_en = 1'b1;
    step(1, 3'd5, 0, 8'hA5);
    check("load_a5", 32'(q), 32'hA5);
    step(1, 3'd1, 1, 8'h00);
    #2 rst = 1'b0;
    #1;
    check("async_q", 32'(q), 32'h00);
    check("async_cnt", 32'(cnt), 0);
    check("async_done", 32'(done), 0);
    #1 rst = 1'b1;

    // 2. PISO
    step(1, 3'd5, 0, 8'hB4);
    exp_l = 8'b1011_0100;
    for (int i = 0; i < 8; i++) begin
      check("piso_sout_l", 32'(sout_l), 32'(exp_l[7-i]));
      step(1, 3'd1, 0, 8'h00);
      check("piso_done", 32'(done), (i == 7) ? 1 : 0);
    end
    check("piso_q", 32'(q), 32'h00);
    check("piso_cnt", 32'(cnt), 0);
    step(1, 3'd0, 0, 8'h00);
    check("piso_done_clr", 32'(done), 0);

    // 3. SIPO
    pat = 8'b1100_1010; // sent MSB first
    dsum = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 3'd2, pat[7-i], 8'h00);
      dsum += int'(done);
    end
    check("sipo_q", 32'(q), 32'h53);
    step(1, 3'd0, 0, 8'h00);
    check("sipo_done_cnt", dsum, 1);

    // 4. rotate
    step(1, 3'd5, 0, 8'h81);
    step(1, 3'd3, 0, 8'h00);
    check("rol_q", 32'(q), 32'h03);
    step(1, 3'd4, 0, 8'h00);
    step(1, 3'd4, 0, 8'h00);
    check("ror_q", 32'(q), 32'hC0);
    check("rot_cnt", 32'(cnt), 3);

    // 5. enable / hold / reserved / clear
    step(1, 3'd5, 0, 8'h3C);
    for (int i = 0; i < 5; i++) step(0, 3'd1, 1, 8'hFF);
    check("en0_q", 32'(q), 32'h3C);
    check("en0_cnt", 32'(cnt), 0);
    step(1, 3'd7, 1, 8'hFF);
    check("rsv_q", 32'(q), 32'h3C);
    step(1, 3'd6, 1, 8'hFF);
    check("clear_q", 32'(q), 32'h00);

    // 6. counter wrap
    step(1, 3'd5, 0, 8'h00);
    dsum = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1, 3'd1, i[0], 8'h00);
      check("wrap_done", 32'(done), (i == 8 || i == 16) ? 1 : 0);
    end
    for (int i = 0; i < 5; i++) step(1, 3'd1, 1, 8'h00);
    check("pre_load_cnt", 32'(cnt), 5);
    step(1, 3'd5, 0, 8'h5A);
    check("post_load_cnt", 32'(cnt), 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 3'd3, 0, 8'h00);
      check("reload_done", 32'(done), (i == 8) ? 1 : 0);
    end
    check("reload_q", 32'(q), 32'h5A);
    step(0, 3'd0, 0, 8'h00);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
